l1_refill_ctrl: RTL



---
 rtl/l1_refill_pkg.sv | 30 +++
 rtl/l1_refill_if.sv | 51 +++++
 rtl/l1_refill_ctrl_timer.sv | 45 ++++
 rtl/l1_refill_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/l1_refill_pkg.sv
// ---------------------------------------------------------------
// l1_refill_pkg : shared types and constants for the L1 refill controller
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package l1_refill_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 255;
  localparam int CNT_WIDTH      = 16;
  localparam int TIMER_WIDTH    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CHECK   = 3'd2,
    L2_WAIT = 3'd3,
    FILL    = 3'd4,
    RESP    = 3'd5
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_refill_if.sv
// ---------------------------------------------------------------
// l1_refill_if : CPU, L1 and L2 signal bundle of the refill controller
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface l1_refill_if
  import l1_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_ready;
  logic                  cpu_done;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_hit;
  logic                  cpu_err;
  logic                  l1_read;
  logic                  l1_write_enable;
  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [DATA_WIDTH-1:0] l1_write_data;
  logic [DATA_WIDTH-1:0] l1_read_data;
  logic                  l1_hit;
  logic                  l2_req;
  logic [ADDR_WIDTH-1:0] l2_addr;
  logic                  l2_ack;
  logic [DATA_WIDTH-1:0] l2_rdata;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  // master = controller side
  modport master (
    input  cpu_req, cpu_addr, l1_read_data, l1_hit, l2_ack, l2_rdata,
    output cpu_ready, cpu_done, cpu_rdata, cpu_hit, cpu_err,
           l1_read, l1_write_enable, l1_addr, l1_write_data,
           l2_req, l2_addr, hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_addr, l1_read_data, l1_hit, l2_ack, l2_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_hit, cpu_err,
           l1_read, l1_write_enable, l1_addr, l1_write_data,
           l2_req, l2_addr, hit_count, miss_count
  );

endinterface

`default_nettype wire

// File: rtl/l1_refill_ctrl_timer.sv
// ---------------------------------------------------------------
// l1_refill_timer : 8-bit L2 wait-cycle counter with clear/enable/expired
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module l1_refill_timer
  import l1_refill_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(LIMIT - 1);

  logic [TIMER_WIDTH-1:0] count_q, count_d;

  // count_q holds the number of completed wait cycles, so the LIMIT-th cycle sees LIMIT-1
  assign expired_o = enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/l1_refill_ctrl.sv
// ---------------------------------------------------------------
// l1_refill_ctrl : L1 lookup / L2 refill controller with hit/miss statistics
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module l1_refill_ctrl
  import l1_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic         clk,
  input logic         rst,
  l1_refill_if.master bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic ready, done, l1_rd, l1_we, l2_req;
  logic tmr_en, tmr_clr, tmr_expired;

  assign tmr_clr = (state_q != L2_WAIT);

  l1_refill_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hit_d      = hit_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    ready      = 1'b0;
    done       = 1'b0;
    l1_rd      = 1'b0;
    l1_we      = 1'b0;
    l2_req     = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          data_d  = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        l1_rd   = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (bus.l1_hit) begin
          data_d    = bus.l1_read_data;
          hit_d     = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = RESP;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = L2_WAIT;
        end
      end
      L2_WAIT: begin
        l2_req = 1'b1;
        tmr_en = 1'b1;
        // an ack on the final allowed cycle still wins over the timeout
        if (bus.l2_ack) begin
          data_d  = bus.l2_rdata;
          state_d = FILL;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end
      end
      FILL: begin
        l1_we   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.cpu_ready       = ready;
  assign bus.cpu_done        = done;
  assign bus.cpu_rdata       = data_q;
  assign bus.cpu_hit         = hit_q;
  assign bus.cpu_err         = err_q;
  assign bus.l1_read         = l1_rd;
  assign bus.l1_write_enable = l1_we;
  assign bus.l1_addr         = addr_q;
  assign bus.l1_write_data   = data_q;
  assign bus.l2_req          = l2_req;
  assign bus.l2_addr         = addr_q;
  assign bus.hit_count       = hit_cnt_q;
  assign bus.miss_count      = miss_cnt_q;

endmodule

`default_nettype wire
